mux_arbiter8: RTL and testbench
===============================

# mux_arbiter8

Round-robin arbiter that shares one downstream request channel among eight requesters. It produces the 3-bit select for the datapath's 8:1 request mux and the one-hot grant vector. It holds each grant through a valid/ready issue handshake and a completion (`m_done`) phase. It sits between the CPU-side requesters (fetch, load/store, uncached, writeback) and the shared memory/bus port.

## Interface
Parameters:
- `TIMEOUT`, 255: maximum cycles in WAIT_DONE before forced release; range 1..65535.
- `TW`, 16: width of the timeout counter; must satisfy 2^TW > TIMEOUT.

Ports:
- `clk`  in  1  system clock, rising edge.
- `resetn`  in  1  asynchronous reset, active-low.
- `req`  in  8  per-requester request level; bit i belongs to requester i.
- `gnt`  out  8  one-hot grant, registered; all-zero when no grant.
- `sel`  out  3  binary index of the granted requester; drives the request mux select.
- `busy`  out  1  high in any state other than IDLE.
- `m_valid`  out  1  downstream request valid; high only in ISSUE.
- `m_ready`  in  1  downstream accepts the request.
- `m_done`  in  1  downstream transaction complete; single-cycle pulse.
- `err`  out  1  one-cycle pulse when a timeout forces release.

## Operation
- States: IDLE, ISSUE, WAIT_DONE.
- Round-robin pointer `ptr[2:0]` is the highest-priority index. Search order is `ptr`, `ptr+1`, …, `ptr+7`, all modulo 8.
- IDLE:
  - If `req != 0`, latch winner w.
  - Next cycle: `gnt = 1<<w`, `sel = w`, `m_valid = 1`, state ISSUE.
  - If `req == 0`, stay in IDLE.
- ISSUE:
  - `m_valid & m_ready & m_done` → release, go to IDLE.
  - `m_valid & m_ready & !m_done` → WAIT_DONE; `m_valid` drops next cycle; `gnt`/`sel` held.
  - `req[w] == 0` and `m_ready == 0` → abort: go to IDLE, clear `gnt`, `ptr` unchanged.
  - `m_ready` wins over a simultaneous drop of `req[w]`; the handshake completes.
- WAIT_DONE:
  - `req` is ignored; `gnt`/`sel` held.
  - `m_done` → release, go to IDLE.
  - Timeout counter reset to 0 on entry, increments each cycle.
  - Counter reaches TIMEOUT without `m_done` → release, `err` pulses for 1 cycle, go to IDLE.
- Release: `ptr <= w+1` (mod 8; 7 wraps to 0), `gnt <= 0`, `sel` holds its last value.
- `m_done` is ignored in IDLE. `m_done` is also ignored in ISSUE before acceptance (with `m_ready` low).
- Reset values, applied asynchronously while `resetn` is low:
  - `gnt = 0`, `sel = 0`, `busy = 0`, `m_valid = 0`, `err = 0`
  - `ptr = 0`, state IDLE, timeout counter 0
- Reset mid-transaction drops the grant immediately. No completion or `err` is signalled.

## Timing
- Arbitration latency: `req` sampled in IDLE at edge N → `gnt`/`sel`/`m_valid` valid after edge N+1 (1 cycle).
- All outputs are registered; none is combinational from inputs.
- Minimum gap: one IDLE cycle between a release and the next grant. Back-to-back single-beat transactions therefore cost 2 cycles each when `m_ready` and `m_done` are tied high.
- `m_valid` is held until accepted; `sel` stays stable while `m_valid` is high.
- Fairness: a continuously requesting requester waits at most 7 other grants.
- Timeout: `err` is asserted in the cycle after the counter reaches TIMEOUT, coincident with `gnt` = 0.

## Test plan
- Reset, then `req = 8'h00` for 10 cycles → `gnt = 0`, `busy = 0`, `m_valid = 0`, `sel = 0` throughout.
- `req = 8'hFF` held; `m_ready`, `m_done` tied high → grants cycle 0,1,2,…,7,0 with one IDLE cycle between each; `sel` matches the grant index.
- After grant to 5, `req = 8'b0010_0001` → next grant goes to 0, since the pointer wrapped from 6 upward.
- Grant to 3 with `m_ready = 0`, then drop `req[3]` → `gnt` returns to 0 next cycle; `ptr` stays 3, so a re-request from 3 wins again.
- Grant to 2, `m_ready` pulse, no `m_done`, TIMEOUT = 4 → `err` pulses once 4 cycles into WAIT_DONE, `gnt` clears, and the next grant starts its search from 3.
- Assert `resetn = 0` in WAIT_DONE with grant to 6 → `gnt = 0`, `busy = 0` immediately; after reset, `req = 8'h41` grants 0 first.

Source files
------------

// File: rtl/mux_arbiter8.sv
// Round-robin arbiter for eight requesters sharing one downstream request channel.
// Holds each grant through the valid/ready issue handshake and the m_done completion phase.
module mux_arbiter8 #(
    parameter int TIMEOUT = 255,
    parameter int TW      = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] sel,
    output logic       busy,
    output logic       m_valid,
    input  logic       m_ready,
    input  logic       m_done,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      ptr_q, ptr_d;
    logic [2:0]      sel_q, sel_d;
    logic [7:0]      gnt_q, gnt_d;
    logic            busy_q, busy_d;
    logic            m_valid_q, m_valid_d;
    logic            err_q, err_d;
    logic [TW-1:0]   cnt_q, cnt_d;

    logic [2:0]      win;
    logic            win_vld;
    logic [2:0]      idx;
    logic            rel;

    // First requester at or after ptr, wrapping modulo 8.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        idx     = '0;
        for (int k = 0; k < 8; k++) begin
            idx = ptr_q + 3'(k);
            if (!win_vld && req[idx]) begin
                win     = idx;
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        gnt_d     = gnt_q;
        busy_d    = busy_q;
        m_valid_d = m_valid_q;
        err_d     = 1'b0;
        cnt_d     = cnt_q;
        rel       = 1'b0;

        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d   = ISSUE;
                    gnt_d     = 8'b1 << win;
                    sel_d     = win;
                    busy_d    = 1'b1;
                    m_valid_d = 1'b1;
                end
            end
            ISSUE: begin
                // Acceptance takes precedence over the requester withdrawing.
                if (m_ready) begin
                    if (m_done) begin
                        rel = 1'b1;
                    end else begin
                        state_d   = WAIT_DONE;
                        m_valid_d = 1'b0;
                        cnt_d     = '0;
                    end
                end else if (!req[sel_q]) begin
                    state_d   = IDLE;
                    gnt_d     = '0;
                    busy_d    = 1'b0;
                    m_valid_d = 1'b0;
                end
            end
            WAIT_DONE: begin
                if (m_done) begin
                    rel = 1'b1;
                end else if (cnt_q == TW'(TIMEOUT - 1)) begin
                    rel   = 1'b1;
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rel) begin
            state_d   = IDLE;
            ptr_d     = sel_q + 3'd1;
            gnt_d     = '0;
            busy_d    = 1'b0;
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            sel_q     <= '0;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            m_valid_q <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            m_valid_q <= m_valid_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign busy    = busy_q;
    assign m_valid = m_valid_q;
    assign err     = err_q;

endmodule

// File: tb/tb_mux_arbiter8.sv
// Bench for mux_arbiter8: vector table, hand-written corner sequences, and a
// randomized run against a transaction-level reference model.
module tb_mux_arbiter8;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] req = 8'h00;
    logic       m_ready = 1'b0;
    logic       m_done = 1'b0;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       m_valid;
    logic       err;

    int checks = 0;
    int failures = 0;

    mux_arbiter8 #(.TIMEOUT(TO), .TW(16)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .req     (req),
        .gnt     (gnt),
        .sel     (sel),
        .busy    (busy),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_done  (m_done),
        .err     (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] req;
        logic       rdy;
        logic       dn;
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       busy;
        logic       mv;
        logic       err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [7:0] r, input logic rdy, input logic dn,
                                input logic [7:0] g, input logic [2:0] s,
                                input logic b, input logic mv, input logic e);
        vec_t v;
        v.req = r; v.rdy = rdy; v.dn = dn;
        v.gnt = g; v.sel = s; v.busy = b; v.mv = mv; v.err = e;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic [7:0] r, input logic rdy, input logic dn);
        @(negedge clk);
        req = r; m_ready = rdy; m_done = dn;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] outs();
        return {2'b00, gnt, sel, busy, m_valid, err};
    endfunction

    function automatic logic [15:0] pack(input logic [7:0] g, input logic [2:0] s,
                                         input logic b, input logic mv, input logic e);
        return {2'b00, g, s, b, mv, e};
    endfunction

    // Transaction-level reference: phase 0 idle, 1 offering, 2 awaiting completion.
    int   m_phase, m_w, m_sel, m_ptr, m_wait;
    logic m_err;

    task automatic model_reset();
        m_phase = 0; m_w = 0; m_sel = 0; m_ptr = 0; m_wait = 0; m_err = 1'b0;
    endtask

    task automatic model_finish();
        m_ptr = (m_w + 1) % 8;
        m_phase = 0;
    endtask

    task automatic model_step(input logic [7:0] r, input logic rdy, input logic dn);
        m_err = 1'b0;
        if (m_phase == 0) begin
            for (int k = 0; k < 8; k++) begin
                if (m_phase == 0 && r[(m_ptr + k) % 8]) begin
                    m_w = (m_ptr + k) % 8;
                    m_sel = m_w;
                    m_phase = 1;
                end
            end
        end else if (m_phase == 1) begin
            if (rdy) begin
                if (dn) model_finish();
                else begin
                    m_phase = 2;
                    m_wait = 0;
                end
            end else if (!r[m_w]) begin
                m_phase = 0;
            end
        end else begin
            if (dn) model_finish();
            else begin
                m_wait++;
                if (m_wait == TO) begin
                    model_finish();
                    m_err = 1'b1;
                end
            end
        end
    endtask

    function automatic logic [15:0] model_outs();
        logic [7:0] g;
        g = (m_phase != 0) ? (8'h1 << m_w) : 8'h00;
        return pack(g, 3'(m_sel), m_phase != 0, m_phase == 1, m_err);
    endfunction

    initial begin
        logic [7:0] r;
        logic       rdy, dn;
        int         ix;

        // Idle with m_done/m_ready asserted: nothing should happen.
        for (int i = 0; i < 10; i++) tbl.push_back(mk(8'h00, 1'b1, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0));
        // All requesting, single-beat transactions: grants rotate 0..7 then 0.
        for (int i = 0; i < 18; i++) begin
            ix = (i / 2) % 8;
            if (i % 2 == 0) tbl.push_back(mk(8'hFF, 1'b1, 1'b1, 8'h1 << ix, 3'(ix), 1'b1, 1'b1, 1'b0));
            else            tbl.push_back(mk(8'hFF, 1'b1, 1'b1, 8'h00, 3'(ix), 1'b0, 1'b0, 1'b0));
        end
        // Grant 5, then {5,0} requesting: pointer at 6 wraps to 0.
        tbl.push_back(mk(8'h20, 1'b1, 1'b1, 8'h20, 3'd5, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk(8'h20, 1'b1, 1'b1, 8'h00, 3'd5, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(8'h21, 1'b1, 1'b1, 8'h01, 3'd0, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk(8'h21, 1'b1, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0));
        // Grant 2 to move the pointer to 3, then abort on 3 keeps pointer at 3.
        tbl.push_back(mk(8'h04, 1'b1, 1'b1, 8'h04, 3'd2, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk(8'h04, 1'b1, 1'b1, 8'h00, 3'd2, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(8'h08, 1'b0, 1'b0, 8'h08, 3'd3, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk(8'h08, 1'b0, 1'b0, 8'h08, 3'd3, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk(8'h00, 1'b0, 1'b1, 8'h00, 3'd3, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(8'h18, 1'b1, 1'b1, 8'h08, 3'd3, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk(8'h18, 1'b1, 1'b1, 8'h00, 3'd3, 1'b0, 1'b0, 1'b0));
        // m_ready beats a simultaneous request drop; req ignored while waiting.
        tbl.push_back(mk(8'h10, 1'b0, 1'b0, 8'h10, 3'd4, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk(8'h00, 1'b1, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(8'hFF, 1'b0, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(8'hFF, 1'b0, 1'b1, 8'h00, 3'd4, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(8'h00, 1'b1, 1'b1, 8'h00, 3'd4, 1'b0, 1'b0, 1'b0));

        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", outs(), pack(8'h00, 3'd0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].req, tbl[i].rdy, tbl[i].dn);
            chk($sformatf("vec%0d", i), outs(),
                pack(tbl[i].gnt, tbl[i].sel, tbl[i].busy, tbl[i].mv, tbl[i].err));
        end

        // Timeout: grant 2, accept without completion, forced release after TO cycles.
        apply(8'h04, 1'b0, 1'b0);
        chk("to_grant", outs(), pack(8'h04, 3'd2, 1'b1, 1'b1, 1'b0));
        apply(8'h00, 1'b1, 1'b0);
        chk("to_wait0", outs(), pack(8'h04, 3'd2, 1'b1, 1'b0, 1'b0));
        for (int i = 1; i < TO; i++) begin
            apply(8'h00, 1'b0, 1'b0);
            chk($sformatf("to_wait%0d", i), outs(), pack(8'h04, 3'd2, 1'b1, 1'b0, 1'b0));
        end
        apply(8'h00, 1'b0, 1'b0);
        chk("to_err", outs(), pack(8'h00, 3'd2, 1'b0, 1'b0, 1'b1));
        apply(8'h0D, 1'b0, 1'b0);
        chk("to_next_from3", outs(), pack(8'h08, 3'd3, 1'b1, 1'b1, 1'b0));
        apply(8'h0D, 1'b1, 1'b1);
        chk("to_release", outs(), pack(8'h00, 3'd3, 1'b0, 1'b0, 1'b0));

        // Asynchronous reset while waiting on grant 6.
        apply(8'h40, 1'b0, 1'b0);
        chk("rst_grant6", outs(), pack(8'h40, 3'd6, 1'b1, 1'b1, 1'b0));
        apply(8'h00, 1'b1, 1'b0);
        chk("rst_wait6", outs(), pack(8'h40, 3'd6, 1'b1, 1'b0, 1'b0));
        @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("rst_async", outs(), pack(8'h00, 3'd0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        resetn = 1'b1;
        apply(8'h41, 1'b0, 1'b0);
        chk("rst_ptr0", outs(), pack(8'h01, 3'd0, 1'b1, 1'b1, 1'b0));

        // Randomized run against the reference model.
        @(negedge clk);
        resetn = 1'b0;
        req = 8'h00; m_ready = 1'b0; m_done = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            r   = 8'($urandom) & 8'($urandom);
            rdy = ($urandom_range(0, 2) == 0);
            dn  = ($urandom_range(0, 3) == 0);
            apply(r, rdy, dn);
            model_step(r, rdy, dn);
            chk($sformatf("rand%0d", i), outs(), model_outs());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
